// File: rtl/agc_loop_ctrl_pkg.sv
// Shared types and constants for the AGC loop controller and its power-estimator partner.
package agc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_TRIG,
    ST_WAIT,
    ST_UPDATE
  } agc_state_e;

  localparam int unsigned GAIN_W_DEF    = 8;
  localparam int unsigned ERR_W         = 10;
  localparam int unsigned FRAC_W        = 4;
  localparam int unsigned DB_W          = 9;
  localparam int unsigned SHIFT_ACQ_DEF = 1;
  localparam int unsigned SHIFT_TRK_DEF = 3;
  localparam int unsigned LOCK_N_DEF    = 4;
  localparam int unsigned TIMEOUT_DEF   = 16;
  localparam int unsigned PWR_EST_LAT   = 12;

  // Magnitude of a dB error; the operands are 9-bit unsigned so -e never overflows.
  function automatic logic [ERR_W-1:0] err_mag(input logic signed [ERR_W-1:0] e);
    logic [ERR_W-1:0] r;
    r = e[ERR_W-1] ? -e : e;
    return r;
  endfunction

endpackage

// File: rtl/agc_loop_ctrl_if.sv
// Measurement handshake with power_est plus gain/status outputs toward the tuner.
interface agc_loop_ctrl_if
  import agc_pkg::*;
#(
  parameter int unsigned GAIN_W = GAIN_W_DEF
);
  logic              log_start;
  logic [DB_W-1:0]   pwr_est_dB;
  logic              pwr_est_end;
  logic [GAIN_W-1:0] gain_code;
  logic              gain_vld;
  logic              agc_lock;
  logic              meas_timeout;

  modport master (
    output log_start, gain_code, gain_vld, agc_lock, meas_timeout,
    input  pwr_est_dB, pwr_est_end
  );

  modport slave (
    input  log_start, gain_code, gain_vld, agc_lock, meas_timeout,
    output pwr_est_dB, pwr_est_end
  );
endinterface

// File: rtl/agc_loop_ctrl_gain_acc.sv
// Gain accumulator: shifts the dB error, accumulates with clamping, registers gain_code/gain_vld.
module agc_gain_acc
  import agc_pkg::*;
#(
  parameter int unsigned GAIN_W    = GAIN_W_DEF,
  parameter int unsigned GAIN_INIT = 128,
  parameter int unsigned GAIN_MIN  = 0,
  parameter int unsigned GAIN_MAX  = 255,
  parameter int unsigned SHIFT_ACQ = SHIFT_ACQ_DEF,
  parameter int unsigned SHIFT_TRK = SHIFT_TRK_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_init,
  input  logic                    upd_en,
  input  logic                    trk,
  input  logic signed [ERR_W-1:0] err,
  output logic [GAIN_W-1:0]       gain_code,
  output logic                    gain_vld
);
  localparam int unsigned ACC_W = GAIN_W + FRAC_W;
  localparam int unsigned SUM_W = ACC_W + 2;
  localparam logic [ACC_W-1:0]        ACC_INIT = ACC_W'(GAIN_INIT * (2**FRAC_W));
  localparam logic signed [SUM_W-1:0] ACC_LO   = SUM_W'(GAIN_MIN * (2**FRAC_W));
  localparam logic signed [SUM_W-1:0] ACC_HI   = SUM_W'(GAIN_MAX * (2**FRAC_W) + (2**FRAC_W - 1));

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    gain_vld_q;
  logic signed [ERR_W-1:0] step;
  logic signed [SUM_W-1:0] step_x, acc_x, sum, sat;

  always_comb begin
    step   = trk ? (err >>> SHIFT_TRK) : (err >>> SHIFT_ACQ);
    step_x = {{(SUM_W-ERR_W){step[ERR_W-1]}}, step};
    acc_x  = {2'b00, acc_q};
    sum    = acc_x + step_x;
    if (sum < ACC_LO)      sat = ACC_LO;
    else if (sum > ACC_HI) sat = ACC_HI;
    else                   sat = sum;

    acc_d = acc_q;
    if (load_init)   acc_d = ACC_INIT;
    else if (upd_en) acc_d = ACC_W'(sat);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= ACC_INIT;
      gain_vld_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      gain_vld_q <= (acc_d[ACC_W-1:FRAC_W] != acc_q[ACC_W-1:FRAC_W]);
    end
  end

  assign gain_code = acc_q[ACC_W-1:FRAC_W];
  assign gain_vld  = gain_vld_q;
endmodule

// File: rtl/agc_loop_ctrl.sv
// Closed-loop AGC sequencer: settle, trigger power_est, capture result, update gain, track lock.
module agc_loop_ctrl
  import agc_pkg::*;
#(
  parameter int unsigned GAIN_W    = GAIN_W_DEF,
  parameter int unsigned GAIN_INIT = 128,
  parameter int unsigned GAIN_MIN  = 0,
  parameter int unsigned GAIN_MAX  = 255,
  parameter int unsigned SHIFT_ACQ = SHIFT_ACQ_DEF,
  parameter int unsigned SHIFT_TRK = SHIFT_TRK_DEF,
  parameter int unsigned LOCK_N    = LOCK_N_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               agc_en,
  input  logic               agc_hold,
  input  logic [DB_W-1:0]    target_db,
  input  logic [15:0]        settle_len,
  input  logic [5:0]         deadband,
  agc_loop_ctrl_if.master    bus
);
  localparam int unsigned     LC_W    = $clog2(LOCK_N + 1);
  localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [LC_W-1:0] LC_MAX  = LC_W'(LOCK_N);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  agc_state_e              state_q;
  logic [15:0]             settle_cnt_q;
  logic [TO_W-1:0]         to_cnt_q;
  logic [LC_W-1:0]         lock_cnt_q, lock_cnt_inc;
  logic                    agc_lock_q, log_start_q, meas_to_q;
  logic [DB_W-1:0]         pwr_q;
  logic [15:0]             settle_load;
  logic signed [ERR_W-1:0] err;
  logic [ERR_W-1:0]        err_abs;
  logic                    in_band, out_band;
  logic [GAIN_W-1:0]       gain_code_w;
  logic                    gain_vld_w;

  always_comb begin
    settle_load  = (settle_len == '0) ? 16'd1 : settle_len;
    err          = $signed({1'b0, target_db}) - $signed({1'b0, pwr_q});
    err_abs      = err_mag(err);
    in_band      = err_abs <= ERR_W'(deadband);
    out_band     = err_abs > ERR_W'({deadband, 1'b0});
    lock_cnt_inc = (lock_cnt_q == LC_MAX) ? lock_cnt_q : lock_cnt_q + LC_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
      lock_cnt_q   <= '0;
      agc_lock_q   <= 1'b0;
      log_start_q  <= 1'b0;
      meas_to_q    <= 1'b0;
      pwr_q        <= '0;
    end else begin
      log_start_q <= 1'b0;
      meas_to_q   <= 1'b0;
      if (!agc_en) begin
        state_q    <= ST_IDLE;
        lock_cnt_q <= '0;
        agc_lock_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            settle_cnt_q <= settle_load;
            state_q      <= ST_SETTLE;
          end
          ST_SETTLE: begin
            settle_cnt_q <= settle_cnt_q - 16'd1;
            if (settle_cnt_q <= 16'd1) begin
              log_start_q <= 1'b1;
              state_q     <= ST_TRIG;
            end
          end
          ST_TRIG: begin
            // Counting from 1 makes expiry land TIMEOUT cycles after the log_start cycle.
            to_cnt_q <= TO_W'(1);
            state_q  <= ST_WAIT;
          end
          ST_WAIT: begin
            if (bus.pwr_est_end) begin
              pwr_q   <= bus.pwr_est_dB;
              state_q <= ST_UPDATE;
            end else if (to_cnt_q >= TO_LAST) begin
              meas_to_q    <= 1'b1;
              settle_cnt_q <= settle_load;
              state_q      <= ST_SETTLE;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end
          ST_UPDATE: begin
            if (in_band) begin
              lock_cnt_q <= lock_cnt_inc;
              if (lock_cnt_inc == LC_MAX) agc_lock_q <= 1'b1;
            end else if (out_band) begin
              lock_cnt_q <= '0;
              agc_lock_q <= 1'b0;
            end
            settle_cnt_q <= settle_load;
            state_q      <= ST_SETTLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  agc_gain_acc #(
    .GAIN_W   (GAIN_W),
    .GAIN_INIT(GAIN_INIT),
    .GAIN_MIN (GAIN_MIN),
    .GAIN_MAX (GAIN_MAX),
    .SHIFT_ACQ(SHIFT_ACQ),
    .SHIFT_TRK(SHIFT_TRK)
  ) u_gain_acc (
    .clk      (clk),
    .reset    (reset),
    .load_init((state_q == ST_IDLE) && agc_en),
    .upd_en   ((state_q == ST_UPDATE) && agc_en && !agc_hold),
    .trk      (agc_lock_q),
    .err      (err),
    .gain_code(gain_code_w),
    .gain_vld (gain_vld_w)
  );

  assign bus.log_start    = log_start_q;
  assign bus.gain_code    = gain_code_w;
  assign bus.gain_vld     = gain_vld_w;
  assign bus.agc_lock     = agc_lock_q;
  assign bus.meas_timeout = meas_to_q;
endmodule
